clk_en_gen: RTL

Parametrised, fully synchronous clock-enable generator for the NES emulator core. It produces NUM_CH independent divided-rate enable strobes (`ce`) and matching 50%-duty square waves (`sq`) from a single system clock. Every downstream block stays on `clk` and qualifies its logic with `ce`. Divide ratios are runtime-programmable, channels can be cascaded, and all channels can be phase-realigned on demand.

---
 rtl/nes_clk_pkg.sv | 24 ++
 rtl/clk_en_chan.sv | 96 +++++++++
 rtl/clk_en_gen.sv | 72 +++++++
 3 files changed

// File: rtl/nes_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nes_clk_pkg
//  Description : Shared constants and helpers for the NES clock-enable
//                generator: default counter width, NES master-clock divide
//                ratios and the channel-select width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package nes_clk_pkg;

    // Default divisor/counter width for clock-enable channels.
    localparam int NES_CNT_W = 8;

    // NES ratios expressed as divisors (period = divisor + 1 master clocks).
    localparam int MASTER_TO_CPU_DIV = 11;  // CPU runs at master / 12
    localparam int MASTER_TO_PPU_DIV = 3;   // PPU runs at master / 4

    // Width of the channel-select field; never narrower than one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_en_chan
//  Description : One clock-enable channel: programmable down-counter that
//                emits a one-cycle ce strobe every div+1 ticks and a square
//                wave that toggles on each strobe.
//  Ports       : clk, rst        - system clock, synchronous active-high reset
//                i_run           - global count enable
//                i_casc_src      - previous channel's ce (cascade qualifier)
//                i_resync        - realign request
//                i_we            - write strobe for i_div / i_casc
//                i_div, i_casc   - new divisor and cascade bit
//                o_ce, o_sq      - registered strobe and square wave
//  Revision    : 1.0  initial release
// ============================================================================
module clk_en_chan
    import nes_clk_pkg::*;
#(
    parameter int               CNT_W   = NES_CNT_W,
    parameter logic [CNT_W-1:0] RST_D   = '0,
    parameter bit               RST_C   = 1'b0,
    parameter bit               CASC_OK = 1'b0   // channel has a predecessor
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_casc_src,
    input  logic             i_resync,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_casc,
    output logic             o_ce,
    output logic             o_sq
);

    logic [CNT_W-1:0] r_div_q;
    logic [CNT_W-1:0] w_div_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_casc_q;
    logic             w_casc_d;
    logic             r_ce_q;
    logic             w_ce_d;
    logic             r_sq_q;
    logic             w_sq_d;
    logic             w_tick;

    always_comb begin
        w_div_d  = i_we ? i_div  : r_div_q;
        w_casc_d = i_we ? i_casc : r_casc_q;
        // The cascade bit of the first channel has no source and is ignored.
        w_tick   = i_run & ((CASC_OK & r_casc_q) ? i_casc_src : 1'b1);

        w_cnt_d  = r_cnt_q;
        w_ce_d   = 1'b0;
        w_sq_d   = r_sq_q;

        if (i_resync) begin
            // Load the divisor as it stands after this edge so that a write
            // landing together with the resync is honoured immediately.
            w_cnt_d = w_div_d;
            w_sq_d  = 1'b0;
        end else if (w_tick) begin
            if (r_cnt_q == '0) begin
                // A write on the reload edge starts the next period with the
                // new value; the period just ending used the old one.
                w_cnt_d = w_div_d;
                w_ce_d  = 1'b1;
                w_sq_d  = ~r_sq_q;
            end else begin
                w_cnt_d = r_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_q  <= RST_D;
            r_casc_q <= RST_C;
            r_cnt_q  <= RST_D;
            r_ce_q   <= 1'b0;
            r_sq_q   <= 1'b0;
        end else begin
            r_div_q  <= w_div_d;
            r_casc_q <= w_casc_d;
            r_cnt_q  <= w_cnt_d;
            r_ce_q   <= w_ce_d;
            r_sq_q   <= w_sq_d;
        end
    end

    assign o_ce = r_ce_q;
    assign o_sq = r_sq_q;

endmodule
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_en_gen
//  Description : NUM_CH independent, runtime-programmable clock-enable
//                channels with optional cascading and global realignment.
//  Ports       : clk, rst   - system clock, synchronous active-high reset
//                run        - global count enable
//                resync     - realign all channels
//                cfg_we     - configuration write strobe
//                cfg_ch     - target channel (writes beyond NUM_CH-1 ignored)
//                cfg_div    - new divisor (period = cfg_div + 1 ticks)
//                cfg_casc   - new cascade bit
//                ce, sq     - per-channel strobes and square waves
//  Revision    : 1.0  initial release
// ============================================================================
module clk_en_gen
    import nes_clk_pkg::*;
#(
    parameter int                      NUM_CH   = 4,
    parameter int                      CNT_W    = NES_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0] RST_DIV  = '0,
    parameter logic [NUM_CH-1:0]       RST_CASC = '0,
    localparam int                     CH_W     = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              resync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_casc,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [CH_W-1:0] c_idx = CH_W'(gi);

        logic w_src;
        logic w_we;

        if (gi == 0) begin : g_head
            assign w_src = 1'b0;
        end else begin : g_link
            assign w_src = ce[gi-1];
        end

        // Out-of-range channel numbers match no index and are dropped here.
        assign w_we = cfg_we & (cfg_ch == c_idx);

        clk_en_chan #(
            .CNT_W   (CNT_W),
            .RST_D   (RST_DIV[gi*CNT_W +: CNT_W]),
            .RST_C   (RST_CASC[gi]),
            .CASC_OK (gi > 0)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_run      (run),
            .i_casc_src (w_src),
            .i_resync   (resync),
            .i_we       (w_we),
            .i_div      (cfg_div),
            .i_casc     (cfg_casc),
            .o_ce       (ce[gi]),
            .o_sq       (sq[gi])
        );
    end

endmodule
`default_nettype wire
